mem_write_checker: RTL and testbench

//  Synthesizable monitor on the data-memory write port of the multi-cycle MIPS core (top: writedata, adr, memwrite).

---
 rtl/mem_write_checker_pkg.sv | 15 +
 rtl/mem_write_checker_sync_fifo.sv | 74 +++++++
 rtl/mem_write_checker.sv | 115 +++++++++++
 tb/tb_mem_write_checker.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_write_checker_pkg.sv
// Shared definitions for the data-memory write checker.
//   state_e  : verdict FSM states (RUN, PASS, FAIL, TMO); PASS/FAIL/TMO are terminal.
//   LOG_W    : width of one store-log entry ({adr, writedata}).
package mem_write_checker_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2,
    ST_TMO  = 2'd3
  } state_e;

  localparam int LOG_W = 64;

endpackage : mem_write_checker_pkg

// File: rtl/mem_write_checker_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset (pointers/count cleared)
//   push   in   write wdata; accepted if not full, or if a pop happens the same cycle
//   pop    in   consume head entry; ignored while empty
//   wdata  in   WIDTH-bit entry to write
//   rdata  out  head entry, valid while !empty; driven 0 when empty
//   full   out  DEPTH entries stored
//   empty  out  no entries stored
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; empty masks rdata, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule : sync_fifo

// File: rtl/mem_write_checker.sv
// mem_write_checker: monitor on the MIPS core data-memory write port.
// Logs every store in a FIFO and decides PASS / FAIL / TIMEOUT for the run.
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   memwrite     in   store strobe (X is treated as no store)
//   adr          in   store address
//   writedata    in   store data
//   log_pop      in   consume head log entry (ignored while log empty)
//   log_valid    out  log non-empty; head on log_adr/log_data
//   log_adr      out  head entry address (0 when empty)
//   log_data     out  head entry data (0 when empty)
//   log_overflow out  sticky: a store was dropped because the log was full
//   done         out  any verdict reached
//   pass         out  EXP_DATA was stored to EXP_ADR
//   fail         out  some other value was stored to EXP_ADR
//   timeout      out  TIMEOUT cycles in RUN elapsed without a verdict
//   write_count  out  number of stores seen, saturating
module mem_write_checker
  import mem_write_checker_pkg::*;
#(
  parameter logic [31:0] EXP_ADR   = 32'h0000_0000,
  parameter logic [31:0] EXP_DATA  = 32'h0000_0005,
  parameter int          TIMEOUT   = 1000,
  parameter int          LOG_DEPTH = 8,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic [31:0]      adr,
  input  logic [31:0]      writedata,
  input  logic             log_pop,
  output logic             log_valid,
  output logic [31:0]      log_adr,
  output logic [31:0]      log_data,
  output logic             log_overflow,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [CNT_W-1:0] write_count
);

  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] write_count_q, write_count_d;
  logic             overflow_q, overflow_d;
  logic             store, exp_hit;
  logic             fifo_full, fifo_empty;
  logic [LOG_W-1:0] fifo_rdata;

  sync_fifo #(
    .WIDTH (LOG_W),
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk   (clk),
    .reset (reset),
    .push  (store),
    .pop   (log_pop),
    .wdata ({adr, writedata}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    // An X strobe takes the else branch in simulation, so it counts as no store.
    store = 1'b0;
    if (memwrite) store = 1'b1;
    exp_hit = store && (adr == EXP_ADR);

    // A store verdict takes priority over the timeout in the same cycle.
    state_d = state_q;
    if (state_q == ST_RUN) begin
      if (exp_hit)                        state_d = (writedata == EXP_DATA) ? ST_PASS : ST_FAIL;
      else if (cycle_cnt_q == LAST_CYCLE) state_d = ST_TMO;
    end

    cycle_cnt_d = cycle_cnt_q;
    if (state_q == ST_RUN) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);

    write_count_d = write_count_q;
    if (store && (write_count_q != '1)) write_count_d = write_count_q + CNT_W'(1);

    // Dropped only when full and the head is not leaving this cycle.
    overflow_d = overflow_q | (store & fifo_full & ~(log_pop & ~fifo_empty));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      cycle_cnt_q   <= '0;
      write_count_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cycle_cnt_q   <= cycle_cnt_d;
      write_count_q <= write_count_d;
      overflow_q    <= overflow_d;
    end
  end

  assign pass         = (state_q == ST_PASS);
  assign fail         = (state_q == ST_FAIL);
  assign timeout      = (state_q == ST_TMO);
  assign done         = pass | fail | timeout;
  assign write_count  = write_count_q;
  assign log_overflow = overflow_q;
  assign log_valid    = ~fifo_empty;
  assign log_adr      = fifo_rdata[63:32];
  assign log_data     = fifo_rdata[31:0];

endmodule : mem_write_checker

// File: tb/tb_mem_write_checker.sv
// Self-checking bench for mem_write_checker: directed scenarios plus random
// store/pop traffic, all compared each cycle against a behavioural model.
module tb_mem_write_checker;

  localparam logic [31:0] EXP_ADR   = 32'h0000_0000;
  localparam logic [31:0] EXP_DATA  = 32'h0000_0005;
  localparam int          TIMEOUT   = 20;
  localparam int          LOG_DEPTH = 8;
  localparam int          CNT_W     = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             memwrite, log_pop;
  logic [31:0]      adr, writedata;
  logic             log_valid, log_overflow, done, pass, fail, timeout;
  logic [31:0]      log_adr, log_data;
  logic [CNT_W-1:0] write_count;

  int checks = 0;
  int errors = 0;

  mem_write_checker #(
    .EXP_ADR   (EXP_ADR),
    .EXP_DATA  (EXP_DATA),
    .TIMEOUT   (TIMEOUT),
    .LOG_DEPTH (LOG_DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .memwrite     (memwrite),
    .adr          (adr),
    .writedata    (writedata),
    .log_pop      (log_pop),
    .log_valid    (log_valid),
    .log_adr      (log_adr),
    .log_data     (log_data),
    .log_overflow (log_overflow),
    .done         (done),
    .pass         (pass),
    .fail         (fail),
    .timeout      (timeout),
    .write_count  (write_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: verdict, store log as a queue, plain integer counters.
  typedef enum {V_RUNNING, V_PASSED, V_FAILED, V_TIMED_OUT} verdict_t;
  verdict_t    m_verdict;
  logic [63:0] m_log[$];
  int          m_cycles;
  int          m_writes;
  bit          m_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_verdict = V_RUNNING;
    m_log.delete();
    m_cycles = 0;
    m_writes = 0;
    m_ovf    = 1'b0;
  endtask

  task automatic model_edge(input bit mw, input logic [31:0] a, input logic [31:0] d, input bit pop);
    bit was_full, popped;
    if (m_verdict == V_RUNNING) begin
      if (mw && a == EXP_ADR)            m_verdict = (d == EXP_DATA) ? V_PASSED : V_FAILED;
      else if (m_cycles == TIMEOUT - 1)  m_verdict = V_TIMED_OUT;
      m_cycles++;
    end
    was_full = (m_log.size() == LOG_DEPTH);
    popped   = pop && (m_log.size() > 0);
    if (popped) void'(m_log.pop_front());
    if (mw) begin
      if (was_full && !popped) m_ovf = 1'b1;
      else                     m_log.push_back({a, d});
      if (m_writes < (1 << CNT_W) - 1) m_writes++;
    end
  endtask

  task automatic check_all(input string tag);
    logic [63:0] head;
    head = (m_log.size() > 0) ? m_log[0] : 64'd0;
    check({tag, ".pass"},     pass,         m_verdict == V_PASSED);
    check({tag, ".fail"},     fail,         m_verdict == V_FAILED);
    check({tag, ".timeout"},  timeout,      m_verdict == V_TIMED_OUT);
    check({tag, ".done"},     done,         m_verdict != V_RUNNING);
    check({tag, ".valid"},    log_valid,    m_log.size() > 0);
    check({tag, ".log_adr"},  log_adr,      head[63:32]);
    check({tag, ".log_data"}, log_data,     head[31:0]);
    check({tag, ".overflow"}, log_overflow, m_ovf);
    check({tag, ".wcount"},   write_count,  m_writes);
  endtask

  // Drive one cycle's inputs now (away from the edge), then check after the edge.
  task automatic step(input string tag, input bit mw, input logic [31:0] a,
                      input logic [31:0] d, input bit pop);
    memwrite  = mw;
    adr       = a;
    writedata = d;
    log_pop   = pop;
    model_edge(mw, a, d, pop);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  // Assert reset asynchronously mid-cycle, check it takes effect at once, then release.
  task automatic apply_reset(input string tag);
    memwrite  = 1'b0;
    adr       = '0;
    writedata = '0;
    log_pop   = 1'b0;
    reset     = 1'b0;
    model_reset();
    #1;
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    memwrite  = 1'b0;
    adr       = '0;
    writedata = '0;
    log_pop   = 1'b0;
    reset     = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b1;

    // 1: correct store on cycle 10 -> pass next cycle, head shows it.
    idle("t1_idle", 9);
    check("t1_pre_pass", pass, 1'b0);
    step("t1_store", 1'b1, 32'h0, 32'h5, 1'b0);
    check("t1_pass", pass, 1'b1);
    check("t1_done", done, 1'b1);
    check("t1_head", {log_adr, log_data}, {32'h0, 32'h5});

    // 2: wrong store first -> fail stays even after a correct one.
    apply_reset("t2");
    step("t2_bad", 1'b1, 32'h0, 32'h7, 1'b0);
    step("t2_good", 1'b1, 32'h0, 32'h5, 1'b0);
    check("t2_fail", fail, 1'b1);
    check("t2_nopass", pass, 1'b0);
    check("t2_wcount", write_count, 16'd2);
    idle("t2_idle", 25);

    // 3: no stores -> timeout exactly TIMEOUT cycles after release.
    apply_reset("t3");
    idle("t3_wait", TIMEOUT - 1);
    check("t3_not_yet", timeout, 1'b0);
    idle("t3_edge", 1);
    check("t3_timeout", timeout, 1'b1);
    check("t3_nopass", pass | fail, 1'b0);

    // 4: 10 stores to a non-decisive address range, no pops -> overflow, 8 logged.
    apply_reset("t4");
    step("t4_st0", 1'b1, 32'd64, 32'h100, 1'b0);
    for (int i = 1; i < 10; i++) step("t4_st", 1'b1, 32'(4 * i), 32'(i + 256), 1'b0);
    check("t4_overflow", log_overflow, 1'b1);
    check("t4_wcount", write_count, 16'd10);
    check("t4_head0", log_adr, 32'd64);
    step("t4_pop0", 1'b0, 32'd0, 32'd0, 1'b1);
    for (int i = 1; i < 8; i++) begin
      check("t4_pop_adr", log_adr, 32'(4 * i));
      step("t4_pop", 1'b0, 32'd0, 32'd0, 1'b1);
    end
    check("t4_empty", log_valid, 1'b0);

    // 5: full log with simultaneous push and pop, then drain and pop on empty.
    apply_reset("t5");
    for (int i = 0; i < LOG_DEPTH; i++) step("t5_fill", 1'b1, 32'(8 + 4 * i), 32'(i), 1'b0);
    step("t5_pushpop", 1'b1, 32'h100, 32'h55, 1'b1);
    check("t5_no_ovf", log_overflow, 1'b0);
    for (int i = 0; i < LOG_DEPTH - 1; i++) step("t5_drain", 1'b0, 32'd0, 32'd0, 1'b1);
    check("t5_tail", {log_adr, log_data}, {32'h100, 32'h55});
    step("t5_last", 1'b0, 32'd0, 32'd0, 1'b1);
    step("t5_pop_empty", 1'b0, 32'd0, 32'd0, 1'b1);
    step("t5_push_pop_empty", 1'b1, 32'h20, 32'h9, 1'b1);
    check("t5_pushed", log_valid, 1'b1);

    // 6: reset mid-run after 3 stores, then the run resumes in RUN.
    apply_reset("t6");
    for (int i = 0; i < 3; i++) step("t6_st", 1'b1, 32'(12 + 4 * i), 32'(i), 1'b0);
    apply_reset("t6_mid");
    check("t6_wcount", write_count, 16'd0);
    step("t6_resume", 1'b1, 32'h0, 32'h5, 1'b0);
    check("t6_pass", pass, 1'b1);

    // Random traffic in several reset-separated segments.
    for (int seg = 0; seg < 6; seg++) begin
      apply_reset("rnd");
      for (int i = 0; i < 40; i++) begin
        bit          mw, pop;
        logic [31:0] a, d;
        mw  = ($urandom_range(0, 2) == 0);
        pop = ($urandom_range(0, 1) == 1);
        a   = 32'(4 * $urandom_range(0, 5));
        d   = ($urandom_range(0, 2) == 0) ? EXP_DATA : $urandom;
        step("rnd", mw, a, d, pop);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mem_write_checker
